pipe_stall_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage pipeline.
- Decides each cycle whether the D-stage instruction must stall, using Tuse/Tnew comparison against the E and M stages.
- Sequences the multi-cycle mult/div unit with a busy counter and stalls HI/LO/md instructions in D while the unit is busy.
- Drives the enables of the F/D pipeline registers and the bubble (sync clear) of the E register. Sits beside the stage registers and is the single source of stall/flush.

---
 rtl/pipe_stall_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl
// Hazard and stall controller for the 5-stage pipeline. It decides each
// cycle whether the D-stage instruction stalls. A stall comes from a
// Tuse/Tnew register hazard against E/M, or from the mult/div unit being busy.
// It is the single source of the F/D enables and of the E bubble.
//
// Optional feature macro: STALL_STAT_EN (adds stall_cnt / stat_clr).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   D_rs, D_rt          D-stage source register addresses
//   D_Tuse_rs/_rt       cycles until each source is needed (3 = unused)
//   D_is_md             D instruction uses the mult/div unit or HI/LO
//   E_wa/E_we/E_Tnew    E-stage destination, write enable, result latency
//   M_wa/M_we/M_Tnew    M-stage destination, write enable, result latency
//   md_start/md_is_div  E-stage mult/div start pulse and its kind
//   stat_clr            (STALL_STAT_EN) clear stall statistics counter
//   stall_cnt           (STALL_STAT_EN) count of stalled cycles, wraps
//   stall               combined stall (combinational)
//   en_F, en_D          F/D register enables (= !stall)
//   clr_E               synchronous clear of E register (= stall)
//   md_busy             mult/div unit busy (from counter register)
// ----------------------------------------------------------------------------
module pipe_stall_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic [1:0]  D_Tuse_rs,
   input  logic [1:0]  D_Tuse_rt,
   input  logic        D_is_md,
   input  logic [4:0]  E_wa,
   input  logic        E_we,
   input  logic [1:0]  E_Tnew,
   input  logic [4:0]  M_wa,
   input  logic        M_we,
   input  logic [1:0]  M_Tnew,
   input  logic        md_start,
   input  logic        md_is_div,
`ifdef STALL_STAT_EN
   input  logic        stat_clr,
   output logic [31:0] stall_cnt,
`endif
   output logic        stall,
   output logic        en_F,
   output logic        en_D,
   output logic        clr_E,
   output logic        md_busy
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned STAT_W = 32;

   logic [CNT_W-1:0] r_md_cnt;
   logic             w_stall_rs;
   logic             w_stall_rt;
   logic             w_stall_md;
   logic             w_stall_raw;

   // Mult/div busy counter: load on start, count down to zero, never wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_md_cnt <= '0;
      end else if (md_start) begin
         r_md_cnt <= md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (r_md_cnt != '0) begin
         r_md_cnt <= r_md_cnt - CNT_W'(1);
      end
   end

   assign md_busy = (r_md_cnt != '0);

   // Register hazards: a producer whose result is not ready in time for
   // the consumer stalls D. $0 is never a hazard, on either side.
   always_comb begin
      w_stall_rs = 1'b0;
      w_stall_rt = 1'b0;
      if (D_rs != 5'd0) begin
         w_stall_rs = (E_we && (E_wa == D_rs) && (E_Tnew > D_Tuse_rs)) ||
                      (M_we && (M_wa == D_rs) && (M_Tnew > D_Tuse_rs));
      end
      if (D_rt != 5'd0) begin
         w_stall_rt = (E_we && (E_wa == D_rt) && (E_Tnew > D_Tuse_rt)) ||
                      (M_we && (M_wa == D_rt) && (M_Tnew > D_Tuse_rt));
      end
   end

   // md hazard includes the cycle in which the start itself sits in E.
   assign w_stall_md  = D_is_md && (md_busy || md_start);
   assign w_stall_raw = w_stall_rs || w_stall_rt || w_stall_md;

   // Reset forces the pipeline to run freely regardless of inputs.
   assign stall = rst ? 1'b0 : w_stall_raw;
   assign en_F  = !stall;
   assign en_D  = !stall;
   assign clr_E = stall;

`ifdef STALL_STAT_EN
   logic [STAT_W-1:0] r_stall_cnt;

   // Stall statistics: clear wins over increment; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         r_stall_cnt <= '0;
      end else if (stall) begin
         r_stall_cnt <= r_stall_cnt + STAT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Self-checking bench for pipe_stall_ctrl. The reference keeps the mult/div
// unit as "busy until cycle N" and evaluates hazards by scanning a table of
// producers against a table of consumers.
// ----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;

   logic        clk;
   logic        rst;
   logic [4:0]  D_rs, D_rt;
   logic [1:0]  D_Tuse_rs, D_Tuse_rt;
   logic        D_is_md;
   logic [4:0]  E_wa, M_wa;
   logic        E_we, M_we;
   logic [1:0]  E_Tnew, M_Tnew;
   logic        md_start, md_is_div;
   logic        stall, en_F, en_D, clr_E, md_busy;
   logic        stat_clr;
`ifdef STALL_STAT_EN
   logic [31:0] stall_cnt;
`endif

   pipe_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk       (clk),
      .rst       (rst),
      .D_rs      (D_rs),
      .D_rt      (D_rt),
      .D_Tuse_rs (D_Tuse_rs),
      .D_Tuse_rt (D_Tuse_rt),
      .D_is_md   (D_is_md),
      .E_wa      (E_wa),
      .E_we      (E_we),
      .E_Tnew    (E_Tnew),
      .M_wa      (M_wa),
      .M_we      (M_we),
      .M_Tnew    (M_Tnew),
      .md_start  (md_start),
      .md_is_div (md_is_div),
`ifdef STALL_STAT_EN
      .stat_clr  (stat_clr),
      .stall_cnt (stall_cnt),
`endif
      .stall     (stall),
      .en_F      (en_F),
      .en_D      (en_D),
      .clr_E     (clr_E),
      .md_busy   (md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference state
   int          cyc     = 0;
   int          md_done = 0;      // unit busy while cyc < md_done
   logic [31:0] m_stat  = '0;
   logic        last_stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic ref_reg_hazard();
      logic [4:0] src  [2];
      logic [1:0] tuse [2];
      logic       pwe  [2];
      logic [4:0] pwa  [2];
      logic [1:0] pnew [2];
      logic       hz = 1'b0;
      src[0] = D_rs;  tuse[0] = D_Tuse_rs;
      src[1] = D_rt;  tuse[1] = D_Tuse_rt;
      pwe[0] = E_we;  pwa[0] = E_wa;  pnew[0] = E_Tnew;
      pwe[1] = M_we;  pwa[1] = M_wa;  pnew[1] = M_Tnew;
      for (int s = 0; s < 2; s++)
         for (int p = 0; p < 2; p++)
            if (src[s] != 0 && pwe[p] && pwa[p] == src[s] &&
                int'(pnew[p]) > int'(tuse[s]))
               hz = 1'b1;
      return hz;
   endfunction

   // Called just after inputs are driven at the negedge: check, then
   // advance the reference across the next posedge.
   task automatic run_cycle();
      logic busy, exp_stall;
      #1;
      busy      = (cyc < md_done);
      exp_stall = !rst && (ref_reg_hazard() || (D_is_md && (busy || md_start)));
      check("stall", 32'(stall), 32'(exp_stall));
      check("en_F",  32'(en_F),  32'(!exp_stall));
      check("en_D",  32'(en_D),  32'(!exp_stall));
      check("clr_E", 32'(clr_E), 32'(exp_stall));
      if (!rst) begin
         check("md_busy", 32'(md_busy), 32'(busy));
`ifdef STALL_STAT_EN
         check("stall_cnt", stall_cnt, m_stat);
`endif
      end
      last_stall = stall;
      if (rst) begin
         md_done = cyc + 1;
         m_stat  = '0;
      end else begin
         if (md_start) md_done = cyc + 1 + (md_is_div ? int'(DIV_N) : int'(MULT_N));
         if (stat_clr)       m_stat = '0;
         else if (exp_stall) m_stat = m_stat + 32'd1;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rst = 1'b0; D_rs = '0; D_rt = '0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
      D_is_md = 1'b0; E_wa = '0; E_we = 1'b0; E_Tnew = '0;
      M_wa = '0; M_we = 1'b0; M_Tnew = '0; md_start = 1'b0; md_is_div = 1'b0;
      stat_clr = 1'b0;
   endtask

   int n_busy, n_stall;

   initial begin
      idle_inputs();
      @(negedge clk);

      // reset with hazardous inputs still presented: outputs must be free-running
      rst = 1'b1; D_rs = 5'd1; E_we = 1'b1; E_wa = 5'd1; E_Tnew = 2'd2;
      D_Tuse_rs = 2'd0; D_is_md = 1'b1; md_start = 1'b1;
      run_cycle();
      run_cycle();
      idle_inputs();
      run_cycle();
      check("rst_busy", 32'(md_busy), 32'd0);

      // lw $1 in E, add uses $1 in D: stall, then resolves once in M with Tnew=1
      E_we = 1'b1; E_wa = 5'd1; E_Tnew = 2'd2; D_rs = 5'd1; D_Tuse_rs = 2'd1;
      #1 check("lw_stall", 32'(stall), 32'd1);
      run_cycle();
      E_we = 1'b0; E_wa = '0; E_Tnew = '0; M_we = 1'b1; M_wa = 5'd1; M_Tnew = 2'd1;
      #1 check("lw_resolved", 32'(stall), 32'd0);
      run_cycle();

      // write to $0 never stalls
      idle_inputs();
      E_wa = 5'd0; E_we = 1'b1; E_Tnew = 2'd2; D_rs = 5'd0; D_Tuse_rs = 2'd0;
      #1 check("zero_reg", 32'(stall), 32'd0);
      run_cycle();

      // mult with mflo waiting in D: start cycle plus MULT_N cycles stall
      idle_inputs();
      n_busy = 0; n_stall = 0;
      D_is_md = 1'b1; md_start = 1'b1; md_is_div = 1'b0;
      for (int i = 0; i < 12; i++) begin
         run_cycle();
         n_stall += int'(last_stall);
         md_start = 1'b0;
         n_busy  += int'(md_busy);
      end
      check("mult_stall_cycles", 32'(n_stall), 32'(MULT_N + 1));
      check("mult_busy_cycles",  32'(n_busy),  32'(MULT_N));

      // div with non-md instruction in D: no stall, busy DIV_N cycles
      idle_inputs();
      n_busy = 0; n_stall = 0;
      md_start = 1'b1; md_is_div = 1'b1;
      for (int i = 0; i < 14; i++) begin
         run_cycle();
         n_stall += int'(last_stall);
         md_start = 1'b0;
         n_busy  += int'(md_busy);
      end
      check("div_stall_cycles", 32'(n_stall), 32'd0);
      check("div_busy_cycles",  32'(n_busy),  32'(DIV_N));

      // reset mid-div (counter at 6): unit idle afterwards, md no longer stalls
      idle_inputs();
      md_start = 1'b1; md_is_div = 1'b1;
      run_cycle();
      md_start = 1'b0;
      for (int i = 0; i < 4; i++) run_cycle();
      check("div_mid_busy", 32'(md_busy), 32'd1);
      rst = 1'b1;
      run_cycle();
      rst = 1'b0; D_is_md = 1'b1;
      #1 check("post_rst_busy",  32'(md_busy), 32'd0);
      check("post_rst_stall", 32'(stall), 32'd0);
      run_cycle();

`ifdef STALL_STAT_EN
      // seven stalls counted, clear beats increment, wrap to zero
      idle_inputs();
      stat_clr = 1'b1;
      run_cycle();
      stat_clr = 1'b0;
      E_we = 1'b1; E_wa = 5'd3; E_Tnew = 2'd2; D_rt = 5'd3; D_Tuse_rt = 2'd0;
      for (int i = 0; i < 7; i++) run_cycle();
      #1 check("stat_seven", stall_cnt, 32'd7);
      stat_clr = 1'b1;
      run_cycle();
      stat_clr = 1'b0;
      #1 check("stat_clr_wins", stall_cnt, 32'd0);
      force dut.r_stall_cnt = 32'hFFFF_FFFF;
      #1 release dut.r_stall_cnt;
      m_stat = 32'hFFFF_FFFF;
      run_cycle();
      #1 check("stat_wrap", stall_cnt, 32'd0);
`endif

      // randomized traffic against the reference
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 63) == 0);
         D_rs      = 5'($urandom_range(0, 3));
         D_rt      = 5'($urandom_range(0, 3));
         D_Tuse_rs = 2'($urandom_range(0, 3));
         D_Tuse_rt = 2'($urandom_range(0, 3));
         D_is_md   = 1'($urandom_range(0, 1));
         E_wa      = 5'($urandom_range(0, 3));
         E_we      = 1'($urandom_range(0, 1));
         E_Tnew    = 2'($urandom_range(0, 2));
         M_wa      = 5'($urandom_range(0, 3));
         M_we      = 1'($urandom_range(0, 1));
         M_Tnew    = 2'($urandom_range(0, 1));
         md_start  = ($urandom_range(0, 7) == 0);
         md_is_div = 1'($urandom_range(0, 1));
         stat_clr  = ($urandom_range(0, 15) == 0);
         run_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
